score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//   Producer side of the score interface: keeps the running game score, the session high
//   score and a BCD copy of the score. Counts one point per elapsed game tick plus bonus
//   points on request, and freezes at game over. Sits between game control and the
//   score/HUD drawing logic, which consumes score[31:0] (binary) each frame.
// PARAMETERS
//   TICK_DIV   10_000_000  clk cycles per survival point (100 MHz -> 10 points/s); >= 2
//   BONUS      10          points added per bonus pulse; 1..98
//   MAX_SCORE  9999        saturation value (4 display digits)
// PORTS
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   1-cycle pulse: new game (clear score, enter RUN)
//   pause       in   1   level: hold score while high (RUN only)
//   bonus       in   1   1-cycle pulse: add BONUS points (RUN only)
//   game_over   in   1   1-cycle pulse: stop counting, commit high score
//   score       out  32  current score, binary, zero-extended
//   score_bcd   out  16  current score as 4 BCD digits {thou,hund,ten,unit}
//   high_score  out  32  best score since reset, binary
//   running     out  1   1 while in RUN
//   new_high    out  1   1 from the cycle after a game over that beat high_score until next start
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; score=0, score_bcd=16'h0000, high_score=0,
//   running=0, new_high=0, prescaler=0. All outputs registered.
// - States: IDLE -start-> RUN; RUN -pause=1-> PAUSED; PAUSED -pause=0-> RUN;
//   RUN/PAUSED -game_over-> OVER; any state -start-> RUN (restart). start beats game_over
//   when both are high in the same cycle. running=1 exactly in RUN (registered with state).
// - On start: score, score_bcd, prescaler cleared; new_high cleared; high_score kept.
// - Prescaler counts 0..TICK_DIV-1 in RUN only; tick when it wraps from TICK_DIV-1 to 0.
//   Holds its value in PAUSED; cleared on start and in IDLE/OVER.
// - Update in RUN: score_next = score + (tick?1:0) + (bonus?BONUS:0), same cycle, visible
//   on the following clk edge (latency 1). Tick and bonus together add 1+BONUS.
// - Saturation: if score_next > MAX_SCORE, score = MAX_SCORE; no wrap, ticks continue
//   to be ignored at the ceiling.
// - bonus outside RUN (IDLE, PAUSED, OVER) is ignored. pause is ignored outside RUN/PAUSED.
// - score_bcd always equals the decimal digits of score in the same cycle (never lags);
//   update by a BCD adder on the same increment, not by division.
// - game_over in RUN/PAUSED: state OVER, score frozen; an update pending that cycle
//   (tick/bonus) is discarded. Next cycle: if score > high_score then high_score=score
//   and new_high=1; equal score does not set new_high. game_over in IDLE/OVER: ignored.
// - Reset mid-game returns everything (including high_score) to reset values immediately.
// TESTING (TICK_DIV=4, BONUS=10, MAX_SCORE=9999)
// 1. Reset, start, run 40 clk -> score=10, score_bcd=16'h0010, running=1, no wrap glitches.
// 2. Pulse bonus on the same cycle as a tick at score=9 -> score=20, score_bcd=16'h0020.
// 3. pause=1 for 100 clk at score=5, prescaler=2 -> score stays 5; release -> next point
//    after exactly 2 more clk in RUN; bonus during pause ignored.
// 4. Preload via bonus to 9995, run 24 clk -> score=9999, holds at 9999, bcd=16'h9999.
// 5. game_over at score=37 (high=0) -> score frozen 37, high_score=37, new_high=1 next
//    cycle; start -> score=0, new_high=0, high_score=37; second game_over at 37 -> new_high=0.
// 6. start and game_over same cycle in RUN -> RUN, score=0; rst_n low mid-RUN -> all zero.

Source files
------------

// File: rtl/score_if.sv
// Score interface: game control drives the request pulses/levels, the score keeper
// drives the registered score, BCD score, high score and status flags.
interface score_if;
  logic        start;
  logic        pause;
  logic        bonus;
  logic        game_over;
  logic [31:0] score;
  logic [15:0] score_bcd;
  logic [31:0] high_score;
  logic        running;
  logic        new_high;

  modport master (
    output start, pause, bonus, game_over,
    input  score, score_bcd, high_score, running, new_high
  );

  modport slave (
    input  start, pause, bonus, game_over,
    output score, score_bcd, high_score, running, new_high
  );
endinterface

// File: rtl/score_keeper.sv
// Running game score with BCD shadow copy, session high score and game state machine.
// Latency: one clk from tick/bonus/start/game_over to registered outputs.
// No backpressure: requests are sampled every cycle and never stalled.
module score_keeper #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int BONUS     = 10,
  parameter int MAX_SCORE = 9999
) (
  input  logic    clk,
  input  logic    rst_n,
  score_if.slave  sif
);

  localparam int PW = $clog2(TICK_DIV);

  // Elaboration-time only: turns parameter constants into packed BCD digits.
  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  localparam logic [15:0] MAX_BCD    = to_bcd(MAX_SCORE);
  localparam logic [15:0] BONUS_BCD  = to_bcd(BONUS);
  localparam logic [15:0] BONUS1_BCD = to_bcd(BONUS + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;

  state_t          state;
  logic [PW-1:0]   presc_q;
  logic [31:0]     score_q;
  logic [15:0]     bcd_q;
  logic [31:0]     high_q;
  logic            running_q;
  logic            new_high_q;

  logic            active;
  logic            tick;
  logic            do_bonus;
  logic [31:0]     inc_bin;
  logic [15:0]     inc_bcd;
  logic [31:0]     raw_sum;
  logic [15:0]     sum_bcd;
  logic [4:0]      dsum;
  logic            carry;
  logic            sat;
  logic [31:0]     score_next;
  logic [15:0]     bcd_next;

  // Counting happens only in RUN with pause low and no game over pending.
  always_comb begin
    active   = (state == RUN) && !sif.pause && !sif.game_over;
    tick     = active && (presc_q == PW'(TICK_DIV - 1));
    do_bonus = active && sif.bonus;
    inc_bin  = (tick ? 32'd1 : 32'd0) + (do_bonus ? 32'(BONUS) : 32'd0);
    case ({tick, do_bonus})
      2'b11:   inc_bcd = BONUS1_BCD;
      2'b01:   inc_bcd = BONUS_BCD;
      2'b10:   inc_bcd = 16'h0001;
      default: inc_bcd = 16'h0000;
    endcase
    raw_sum = score_q + inc_bin;
  end

  // Digit-serial BCD adder; the final carry is irrelevant because any overflow saturates.
  always_comb begin
    sum_bcd = '0;
    dsum    = '0;
    carry   = 1'b0;
    for (int d = 0; d < 4; d++) begin
      dsum = {1'b0, bcd_q[4*d +: 4]} + {1'b0, inc_bcd[4*d +: 4]} + {4'b0, carry};
      if (dsum > 5'd9) begin
        dsum  = dsum + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum_bcd[4*d +: 4] = dsum[3:0];
    end
  end

  always_comb begin
    sat        = raw_sum > 32'(MAX_SCORE);
    score_next = sat ? 32'(MAX_SCORE) : raw_sum;
    bcd_next   = sat ? MAX_BCD : sum_bcd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      presc_q    <= '0;
      score_q    <= '0;
      bcd_q      <= '0;
      high_q     <= '0;
      running_q  <= 1'b0;
      new_high_q <= 1'b0;
    end else if (sif.start) begin
      state      <= RUN;
      presc_q    <= '0;
      score_q    <= '0;
      bcd_q      <= '0;
      running_q  <= 1'b1;
      new_high_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (sif.game_over) begin
            state      <= OVER;
            running_q  <= 1'b0;
            presc_q    <= '0;
            high_q     <= (score_q > high_q) ? score_q : high_q;
            new_high_q <= score_q > high_q;
          end else if (sif.pause) begin
            state     <= PAUSED;
            running_q <= 1'b0;
          end else begin
            score_q <= score_next;
            bcd_q   <= bcd_next;
            presc_q <= tick ? '0 : presc_q + PW'(1);
          end
        end
        PAUSED: begin
          if (sif.game_over) begin
            state      <= OVER;
            presc_q    <= '0;
            high_q     <= (score_q > high_q) ? score_q : high_q;
            new_high_q <= score_q > high_q;
          end else if (!sif.pause) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        default: presc_q <= '0;
      endcase
    end
  end

  assign sif.score      = score_q;
  assign sif.score_bcd  = bcd_q;
  assign sif.high_score = high_q;
  assign sif.running    = running_q;
  assign sif.new_high   = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with TICK_DIV=4, BONUS=10, MAX_SCORE=9999.
module tb_score_keeper;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  score_if sif ();

  score_keeper #(.TICK_DIV(4), .BONUS(10), .MAX_SCORE(9999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    sif.start = 1'b1;
    cyc(1);
    sif.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sif.start = 1'b0; sif.pause = 1'b0; sif.bonus = 1'b0; sif.game_over = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    n_cmp++; if (sif.score !== 32'd0) begin n_err++; $display("FAIL reset_score: got %0d want 0", sif.score); end
    n_cmp++; if (sif.score_bcd !== 16'h0000) begin n_err++; $display("FAIL reset_bcd: got %h want 0000", sif.score_bcd); end
    n_cmp++; if (sif.high_score !== 32'd0) begin n_err++; $display("FAIL reset_high: got %0d want 0", sif.high_score); end
    n_cmp++; if (sif.running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", sif.running); end
    n_cmp++; if (sif.new_high !== 1'b0) begin n_err++; $display("FAIL reset_new_high: got %b want 0", sif.new_high); end
    // IDLE must not count
    cyc(10);
    n_cmp++; if (sif.score !== 32'd0) begin n_err++; $display("FAIL idle_hold: got %0d want 0", sif.score); end
  endtask

  task automatic test_count();
    pulse_start();
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      n_cmp++;
      if (sif.score !== 32'(i / 4)) begin
        n_err++; $display("FAIL count_step%0d: got %0d want %0d", i, sif.score, i / 4);
      end
    end
    n_cmp++; if (sif.score_bcd !== 16'h0010) begin n_err++; $display("FAIL count_bcd: got %h want 0010", sif.score_bcd); end
    n_cmp++; if (sif.running !== 1'b1) begin n_err++; $display("FAIL count_running: got %b want 1", sif.running); end
  endtask

  task automatic test_bonus_tick();
    pulse_start();
    cyc(39);  // score 9, prescaler 3
    n_cmp++; if (sif.score !== 32'd9) begin n_err++; $display("FAIL pre_bonus: got %0d want 9", sif.score); end
    sif.bonus = 1'b1;
    cyc(1);
    sif.bonus = 1'b0;
    n_cmp++; if (sif.score !== 32'd20) begin n_err++; $display("FAIL bonus_tick: got %0d want 20", sif.score); end
    n_cmp++; if (sif.score_bcd !== 16'h0020) begin n_err++; $display("FAIL bonus_tick_bcd: got %h want 0020", sif.score_bcd); end
  endtask

  task automatic test_pause();
    pulse_start();
    cyc(22);  // score 5, prescaler 2
    sif.pause = 1'b1;
    cyc(1);
    sif.bonus = 1'b1;
    cyc(99);
    sif.bonus = 1'b0;
    n_cmp++; if (sif.score !== 32'd5) begin n_err++; $display("FAIL pause_hold: got %0d want 5", sif.score); end
    n_cmp++; if (sif.running !== 1'b0) begin n_err++; $display("FAIL pause_running: got %b want 0", sif.running); end
    sif.pause = 1'b0;
    cyc(1);
    n_cmp++; if (sif.running !== 1'b1) begin n_err++; $display("FAIL resume_running: got %b want 1", sif.running); end
    cyc(1);
    n_cmp++; if (sif.score !== 32'd5) begin n_err++; $display("FAIL resume_early: got %0d want 5", sif.score); end
    cyc(1);
    n_cmp++; if (sif.score !== 32'd6) begin n_err++; $display("FAIL resume_point: got %0d want 6", sif.score); end
  endtask

  task automatic test_saturate();
    pulse_start();
    sif.bonus = 1'b1;
    cyc(975);  // 9750 bonus + 243 ticks
    sif.bonus = 1'b0;
    n_cmp++; if (sif.score_bcd !== 16'h9993) begin n_err++; $display("FAIL preload_bcd: got %h want 9993", sif.score_bcd); end
    cyc(5);
    n_cmp++; if (sif.score !== 32'd9995) begin n_err++; $display("FAIL preload: got %0d want 9995", sif.score); end
    n_cmp++; if (sif.score_bcd !== 16'h9995) begin n_err++; $display("FAIL preload_bcd2: got %h want 9995", sif.score_bcd); end
    cyc(24);
    n_cmp++; if (sif.score !== 32'd9999) begin n_err++; $display("FAIL sat_score: got %0d want 9999", sif.score); end
    n_cmp++; if (sif.score_bcd !== 16'h9999) begin n_err++; $display("FAIL sat_bcd: got %h want 9999", sif.score_bcd); end
    sif.bonus = 1'b1;
    cyc(1);
    sif.bonus = 1'b0;
    n_cmp++; if (sif.score !== 32'd9999) begin n_err++; $display("FAIL sat_bonus: got %0d want 9999", sif.score); end
  endtask

  task automatic reach_37();
    pulse_start();
    sif.bonus = 1'b1;
    cyc(3);   // 30, prescaler 3
    sif.bonus = 1'b0;
    cyc(25);  // 37, prescaler 0
  endtask

  task automatic test_game_over();
    reach_37();
    n_cmp++; if (sif.score !== 32'd37) begin n_err++; $display("FAIL reach37: got %0d want 37", sif.score); end
    sif.game_over = 1'b1;
    cyc(1);
    sif.game_over = 1'b0;
    n_cmp++; if (sif.running !== 1'b0) begin n_err++; $display("FAIL over_running: got %b want 0", sif.running); end
    cyc(1);
    n_cmp++; if (sif.high_score !== 32'd37) begin n_err++; $display("FAIL over_high: got %0d want 37", sif.high_score); end
    n_cmp++; if (sif.new_high !== 1'b1) begin n_err++; $display("FAIL over_new_high: got %b want 1", sif.new_high); end
    sif.bonus = 1'b1;
    cyc(10);
    sif.bonus = 1'b0;
    n_cmp++; if (sif.score !== 32'd37) begin n_err++; $display("FAIL over_frozen: got %0d want 37", sif.score); end
    n_cmp++; if (sif.new_high !== 1'b1) begin n_err++; $display("FAIL new_high_held: got %b want 1", sif.new_high); end
    pulse_start();
    n_cmp++; if (sif.score !== 32'd0) begin n_err++; $display("FAIL restart_score: got %0d want 0", sif.score); end
    n_cmp++; if (sif.new_high !== 1'b0) begin n_err++; $display("FAIL restart_new_high: got %b want 0", sif.new_high); end
    n_cmp++; if (sif.high_score !== 32'd37) begin n_err++; $display("FAIL restart_high: got %0d want 37", sif.high_score); end
    reach_37();
    cyc(3);   // prescaler 3: tick pending on game_over cycle
    sif.game_over = 1'b1;
    sif.bonus     = 1'b1;
    cyc(1);
    sif.game_over = 1'b0;
    sif.bonus     = 1'b0;
    cyc(1);
    n_cmp++; if (sif.score !== 32'd37) begin n_err++; $display("FAIL over_discard: got %0d want 37", sif.score); end
    n_cmp++; if (sif.new_high !== 1'b0) begin n_err++; $display("FAIL equal_new_high: got %b want 0", sif.new_high); end
    n_cmp++; if (sif.high_score !== 32'd37) begin n_err++; $display("FAIL equal_high: got %0d want 37", sif.high_score); end
  endtask

  task automatic test_start_over_reset();
    pulse_start();
    sif.bonus = 1'b1;
    cyc(1);
    sif.bonus = 1'b0;
    n_cmp++; if (sif.score !== 32'd10) begin n_err++; $display("FAIL so_pre: got %0d want 10", sif.score); end
    sif.start     = 1'b1;
    sif.game_over = 1'b1;
    cyc(1);
    sif.start     = 1'b0;
    sif.game_over = 1'b0;
    n_cmp++; if (sif.running !== 1'b1) begin n_err++; $display("FAIL so_running: got %b want 1", sif.running); end
    n_cmp++; if (sif.score !== 32'd0) begin n_err++; $display("FAIL so_score: got %0d want 0", sif.score); end
    cyc(4);
    n_cmp++; if (sif.score !== 32'd1) begin n_err++; $display("FAIL so_counting: got %0d want 1", sif.score); end
    rst_n = 1'b0;
    #2;
    n_cmp++; if (sif.score !== 32'd0) begin n_err++; $display("FAIL arst_score: got %0d want 0", sif.score); end
    n_cmp++; if (sif.high_score !== 32'd0) begin n_err++; $display("FAIL arst_high: got %0d want 0", sif.high_score); end
    n_cmp++; if (sif.running !== 1'b0) begin n_err++; $display("FAIL arst_running: got %b want 0", sif.running); end
    cyc(2);
    rst_n = 1'b1;
    cyc(8);
    n_cmp++; if (sif.score !== 32'd0) begin n_err++; $display("FAIL post_rst_idle: got %0d want 0", sif.score); end
    n_cmp++; if (sif.running !== 1'b0) begin n_err++; $display("FAIL post_rst_running: got %b want 0", sif.running); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_count();
    test_bonus_tick();
    test_pause();
    test_saturate();
    test_game_over();
    test_start_over_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
